// File: rtl/rx_cmd_decoder.sv
// ============================================================================
// Module   : rx_cmd_decoder
// Purpose  : Assembles synchronized RX bytes into write/read/ALU command frames
//            and issues single-cycle registered register-file and ALU strobes.
//            Optional mid-frame idle timeout: define CMD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  alu_en,
  output logic [FUN_WIDTH-1:0]  alu_fun,
  output logic                  clk_gate_en,
  output logic                  frame_done,
  output logic                  cmd_err
);

  localparam logic [DATA_WIDTH-1:0] c_OP_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] c_OP_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] c_OP_ALU_AB = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] c_OP_ALU    = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_ADDR = 3'd3,
    S_OP_A    = 3'd4,
    S_OP_B    = 3'd5,
    S_ALU_FUN = 3'd6
  } state_t;

  state_t                r_state, w_state_nx;
  logic                  r_wr_en, w_wr_en_nx;
  logic                  r_rd_en, w_rd_en_nx;
  logic                  r_alu_en, w_alu_en_nx;
  logic                  r_frame_done, w_frame_done_nx;
  logic                  r_cmd_err, w_cmd_err_nx;
  logic                  r_clk_gate_en, w_clk_gate_en_nx;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nx;
  logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_nx;
  logic [FUN_WIDTH-1:0]  r_alu_fun, w_alu_fun_nx;
  logic                  w_timeout;

`ifdef CMD_TIMEOUT_EN
  localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_to_cnt;

  // An arriving byte on the expiry cycle takes priority over the abort.
  assign w_timeout = (r_state != S_IDLE) && !rx_valid && (r_to_cnt == c_CNT_MAX);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_IDLE) || rx_valid || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + c_CNT_W'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state       <= S_IDLE;
      r_wr_en       <= 1'b0;
      r_rd_en       <= 1'b0;
      r_alu_en      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_cmd_err     <= 1'b0;
      r_clk_gate_en <= 1'b0;
      r_addr        <= '0;
      r_wr_data     <= '0;
      r_alu_fun     <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_wr_en       <= w_wr_en_nx;
      r_rd_en       <= w_rd_en_nx;
      r_alu_en      <= w_alu_en_nx;
      r_frame_done  <= w_frame_done_nx;
      r_cmd_err     <= w_cmd_err_nx;
      r_clk_gate_en <= w_clk_gate_en_nx;
      r_addr        <= w_addr_nx;
      r_wr_data     <= w_wr_data_nx;
      r_alu_fun     <= w_alu_fun_nx;
    end
  end

  always_comb begin
    w_state_nx       = r_state;
    w_wr_en_nx       = 1'b0;
    w_rd_en_nx       = 1'b0;
    w_alu_en_nx      = 1'b0;
    w_frame_done_nx  = 1'b0;
    w_cmd_err_nx     = 1'b0;
    // The gate survives the alu_en cycle and falls on the one after it.
    w_clk_gate_en_nx = r_clk_gate_en & ~r_alu_en;
    w_addr_nx        = r_addr;
    w_wr_data_nx     = r_wr_data;
    w_alu_fun_nx     = r_alu_fun;

    if (w_timeout) begin
      w_state_nx       = S_IDLE;
      w_cmd_err_nx     = 1'b1;
      w_clk_gate_en_nx = 1'b0;
    end else if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == c_OP_WR) begin
            w_state_nx = S_WR_ADDR;
          end else if (rx_data == c_OP_RD) begin
            w_state_nx = S_RD_ADDR;
          end else if (rx_data == c_OP_ALU_AB) begin
            w_state_nx       = S_OP_A;
            w_clk_gate_en_nx = 1'b1;
          end else if (rx_data == c_OP_ALU) begin
            w_state_nx       = S_ALU_FUN;
            w_clk_gate_en_nx = 1'b1;
          end else begin
            w_cmd_err_nx = 1'b1;
          end
        end
        S_WR_ADDR: begin
          w_addr_nx  = rx_data[ADDR_WIDTH-1:0];
          w_state_nx = S_WR_DATA;
        end
        S_WR_DATA: begin
          w_wr_data_nx    = rx_data;
          w_wr_en_nx      = 1'b1;
          w_frame_done_nx = 1'b1;
          w_state_nx      = S_IDLE;
        end
        S_RD_ADDR: begin
          w_addr_nx       = rx_data[ADDR_WIDTH-1:0];
          w_rd_en_nx      = 1'b1;
          w_frame_done_nx = 1'b1;
          w_state_nx      = S_IDLE;
        end
        S_OP_A: begin
          w_addr_nx    = ADDR_WIDTH'(0);
          w_wr_data_nx = rx_data;
          w_wr_en_nx   = 1'b1;
          w_state_nx   = S_OP_B;
        end
        S_OP_B: begin
          w_addr_nx    = ADDR_WIDTH'(1);
          w_wr_data_nx = rx_data;
          w_wr_en_nx   = 1'b1;
          w_state_nx   = S_ALU_FUN;
        end
        S_ALU_FUN: begin
          w_alu_fun_nx    = rx_data[FUN_WIDTH-1:0];
          w_alu_en_nx     = 1'b1;
          w_frame_done_nx = 1'b1;
          w_state_nx      = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign wr_en       = r_wr_en;
  assign rd_en       = r_rd_en;
  assign addr        = r_addr;
  assign wr_data     = r_wr_data;
  assign alu_en      = r_alu_en;
  assign alu_fun     = r_alu_fun;
  assign clk_gate_en = r_clk_gate_en;
  assign frame_done  = r_frame_done;
  assign cmd_err     = r_cmd_err;

endmodule

`default_nettype wire
